// File: rtl/apb_reg_slave.sv
// APB register responder: 16-bit register bank with programmable wait states and pslverr.
// Optional byte-lane write strobes are enabled by defining APB_SLV_STRB_EN.
module apb_reg_slave #(
  parameter logic [19:0] BASE_ADDR   = 20'h00000,
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     psel,
  input  logic                     penable,
  input  logic                     pwrite,
  input  logic [1:0]               pstrb,
  input  logic [19:0]              paddr,
  input  logic [15:0]              pwdata,
  output logic                     pready,
  output logic [15:0]              prdata,
  output logic                     pslverr,
  input  logic [15:0]              hw_status,
  output logic [16*NUM_REGS-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      reg_wr_o
);

  localparam int              IW       = $clog2(NUM_REGS);
  localparam logic [IW-1:0]   LAST     = IW'(NUM_REGS - 1);
  localparam logic [20:0]     END_ADDR = {1'b0, BASE_ADDR} + 21'(2 * NUM_REGS);
  localparam logic [3:0]      CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                     r_state;
  logic [3:0]                 r_cnt;
  logic [IW-1:0]              r_idx;
  logic                       r_write;
  logic                       r_err;
  logic [1:0]                 r_strb;
  logic [15:0]                r_wdata;
  logic [NUM_REGS-1:0][15:0]  r_regs;

  logic [19:0]   w_off;
  logic [IW-1:0] w_in_idx;
  logic          w_in_err;
  logic [IW-1:0] w_sel_idx;
  logic          w_sel_err;
  logic [15:0]   w_rd_data;
  logic [15:0]   w_mask;
  logic          w_commit;

  // 21-bit compare keeps the upper bound correct when BASE_ADDR sits near the top of the map
  assign w_off    = paddr - BASE_ADDR;
  assign w_in_idx = IW'(w_off >> 1);
  assign w_in_err = (paddr < BASE_ADDR) | ({1'b0, paddr} >= END_ADDR) | paddr[0]
                  | (pwrite & (w_in_idx == LAST));

  // With zero wait states the response is built from the live setup-cycle inputs
  assign w_sel_idx = (r_state == IDLE) ? w_in_idx : r_idx;
  assign w_sel_err = (r_state == IDLE) ? w_in_err : r_err;
  assign w_rd_data = w_sel_err           ? 16'h0000  :
                     (w_sel_idx == LAST) ? hw_status : r_regs[w_sel_idx];

`ifdef APB_SLV_STRB_EN
  assign w_mask   = {{8{r_strb[1]}}, {8{r_strb[0]}}};
  assign w_commit = r_write & ~r_err & (|r_strb);
`else
  logic w_strb_ign;
  // strobes have no effect in this build; the term below is always 0
  assign w_strb_ign = &{1'b0, r_strb};
  assign w_mask     = 16'hFFFF;
  assign w_commit   = r_write & ~r_err & ~w_strb_ign;
`endif

  assign regs_o = r_regs;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_strb   <= '0;
      r_wdata  <= '0;
      r_regs   <= '0;
      pready   <= 1'b0;
      pslverr  <= 1'b0;
      prdata   <= '0;
      reg_wr_o <= '0;
    end else begin
      reg_wr_o <= '0;
      case (r_state)
        IDLE: begin
          if (psel && !penable) begin
            r_idx   <= w_in_idx;
            r_write <= pwrite;
            r_err   <= w_in_err;
            r_strb  <= pstrb;
            r_wdata <= pwdata;
            if (WAIT_STATES == 0) begin
              r_state <= RESP;
              pready  <= 1'b1;
              pslverr <= w_in_err;
              prdata  <= w_rd_data;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            r_state <= IDLE;
          end else if (r_cnt == 4'd0) begin
            r_state <= RESP;
            pready  <= 1'b1;
            pslverr <= r_err;
            prdata  <= w_rd_data;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
          pready  <= 1'b0;
          pslverr <= 1'b0;
          prdata  <= '0;
          if (w_commit) begin
            r_regs[r_idx]   <= (r_regs[r_idx] & ~w_mask) | (r_wdata & w_mask);
            reg_wr_o[r_idx] <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_slave.sv
// Randomized bench for apb_reg_slave: three instances (0, 1, 3 wait states) against a register-array model.
module tb_apb_reg_slave;
  localparam logic [19:0] BASE = 20'h00400;
  localparam int NR = 8;
  localparam int NI = 3;
  localparam int WS_TAB [NI] = '{0, 1, 3};

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NI-1:0] psel;
  logic penable, pwrite;
  logic [1:0] pstrb;
  logic [19:0] paddr;
  logic [15:0] pwdata, hw_status;
  logic [NI-1:0] pready, pslverr;
  logic [15:0] prdata [NI];
  logic [16*NR-1:0] regs [NI];
  logic [NR-1:0] reg_wr [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    apb_reg_slave #(.BASE_ADDR(BASE), .NUM_REGS(NR), .WAIT_STATES(WS_TAB[g])) u_dut (
      .clk(clk), .reset(reset), .psel(psel[g]), .penable(penable), .pwrite(pwrite),
      .pstrb(pstrb), .paddr(paddr), .pwdata(pwdata), .pready(pready[g]),
      .prdata(prdata[g]), .pslverr(pslverr[g]), .hw_status(hw_status),
      .regs_o(regs[g]), .reg_wr_o(reg_wr[g]));
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;
  logic [NR-1:0][15:0] mdl [NI];
  logic [NR-1:0] wr_hot [NI];
  int wr_cyc [NI];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Continuous checks: register image, write pulses, idle-response outputs
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      for (int g = 0; g < NI; g++) begin
        chk($sformatf("regs%0d", g), 128'(regs[g]), 128'(mdl[g]));
        chk($sformatf("wrpulse%0d", g), 128'(reg_wr[g]),
            (wr_cyc[g] == cyc) ? 128'(wr_hot[g]) : 128'(0));
        if (!pready[g]) begin
          chk($sformatf("idle_slverr%0d", g), 128'(pslverr[g]), 128'(0));
          chk($sformatf("idle_prdata%0d", g), 128'(prdata[g]), 128'(0));
        end
      end
    end
  end

  function automatic bit exp_err(input bit wr, input logic [19:0] a);
    int off;
    off = int'(a) - int'(BASE);
    return (off < 0) || (off >= 2 * NR) || a[0] || (wr && (off / 2 == NR - 1));
  endfunction

  // Entered and left at 1 time unit after a rising edge; abort >= 0 drops psel after that many access cycles
  task automatic xfer(input int g, input bit wr, input logic [19:0] a, input logic [15:0] wd,
                      input logic [1:0] st, input int abort, input logic [15:0] hw);
    bit err;
    int idx;
    int n;
    logic [15:0] exp_rd;
    logic [15:0] nv;
    err = exp_err(wr, a);
    idx = (int'(a) - int'(BASE)) / 2;
    hw_status = hw;
    exp_rd = 16'h0000;
    if (!err) begin
      if (idx == NR - 1) exp_rd = hw;
      else exp_rd = mdl[g][idx];
    end
    psel[g] = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    @(posedge clk); #1;
    penable = 1'b1;
    if (abort >= 0) begin
      repeat (abort) begin
        @(negedge clk); chk("abort_early_rdy", 128'(pready[g]), 128'(0));
        @(posedge clk); #1;
      end
      psel[g] = 1'b0; penable = 1'b0;
      repeat (WS_TAB[g] + 2) begin
        @(negedge clk); chk("abort_rdy", 128'(pready[g]), 128'(0));
        @(posedge clk); #1;
      end
      return;
    end
    n = 0;
    forever begin
      n++;
      @(negedge clk);
      if (pready[g] || n >= 20) break;
      @(posedge clk); #1;
    end
    chk($sformatf("latency%0d", g), 128'(n), 128'(WS_TAB[g] + 1));
    chk($sformatf("prdata%0d a=%0h", g, a), 128'(prdata[g]), 128'(exp_rd));
    chk($sformatf("pslverr%0d a=%0h", g, a), 128'(pslverr[g]), 128'(err));
    @(posedge clk); #1;
    psel[g] = 1'b0; penable = 1'b0;
    if (wr && !err) begin
      nv = mdl[g][idx];
`ifdef APB_SLV_STRB_EN
      if (st[0]) nv[7:0] = wd[7:0];
      if (st[1]) nv[15:8] = wd[15:8];
      if (st != 2'b00) begin
        mdl[g][idx] = nv;
        wr_hot[g] = '0; wr_hot[g][idx] = 1'b1; wr_cyc[g] = cyc;
      end
`else
      nv = wd;
      mdl[g][idx] = nv;
      wr_hot[g] = '0; wr_hot[g][idx] = 1'b1; wr_cyc[g] = cyc;
`endif
    end
  endtask

  initial begin
    int g;
    int ab;
    logic [19:0] a;
    psel = '0; penable = 1'b0; pwrite = 1'b0; pstrb = 2'b00;
    paddr = '0; pwdata = '0; hw_status = '0;
    for (int i = 0; i < NI; i++) begin
      mdl[i] = '0; wr_hot[i] = '0; wr_cyc[i] = -1;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("rst_pready", 128'(pready[i]), 128'(0));
      chk("rst_pslverr", 128'(pslverr[i]), 128'(0));
      chk("rst_prdata", 128'(prdata[i]), 128'(0));
      chk("rst_regs", 128'(regs[i]), 128'(0));
      chk("rst_wr", 128'(reg_wr[i]), 128'(0));
    end
    @(posedge clk); #1;
    reset = 1'b0; mon_en = 1'b1;

    // directed cases on the 1-wait-state instance
    xfer(1, 1'b0, BASE + 20'd2, 16'h0, 2'b11, -1, 16'h0);
    xfer(1, 1'b1, BASE + 20'd4, 16'hA5C3, 2'b11, -1, 16'h0);
    chk("a5c3_regs", 128'(regs[1][47:32]), 128'(16'hA5C3));
    xfer(1, 1'b0, BASE + 20'd4, 16'h0, 2'b11, -1, 16'h0);
    xfer(1, 1'b0, BASE + 20'd14, 16'h0, 2'b11, -1, 16'h1234);
    xfer(1, 1'b1, BASE + 20'd14, 16'hFFFF, 2'b11, -1, 16'h1234);
    xfer(1, 1'b0, BASE + 20'd16, 16'h0, 2'b11, -1, 16'h0);
    xfer(1, 1'b1, BASE + 20'd3, 16'h7777, 2'b11, -1, 16'h0);
    xfer(1, 1'b1, BASE - 20'd2, 16'h7777, 2'b11, -1, 16'h0);
    // abort during wait states, then a normal transfer
    xfer(2, 1'b1, BASE + 20'd6, 16'h5555, 2'b11, 1, 16'h0);
    xfer(2, 1'b1, BASE + 20'd6, 16'h6666, 2'b11, 2, 16'h0);
    xfer(2, 1'b1, BASE + 20'd6, 16'h9999, 2'b11, -1, 16'h0);
    xfer(2, 1'b0, BASE + 20'd6, 16'h0, 2'b11, -1, 16'h0);
    // zero wait states, back-to-back
    xfer(0, 1'b1, BASE, 16'h3C3C, 2'b11, -1, 16'h0);
    xfer(0, 1'b0, BASE, 16'h0, 2'b11, -1, 16'h0);
    xfer(0, 1'b0, BASE + 20'd14, 16'h0, 2'b11, -1, 16'hCAFE);
    // byte strobes
    xfer(1, 1'b1, BASE + 20'd8, 16'h1200, 2'b11, -1, 16'h0);
    xfer(1, 1'b1, BASE + 20'd8, 16'hBEEF, 2'b01, -1, 16'h0);
`ifdef APB_SLV_STRB_EN
    chk("strb_lo", 128'(regs[1][79:64]), 128'(16'h12EF));
`else
    chk("strb_lo", 128'(regs[1][79:64]), 128'(16'hBEEF));
`endif
    xfer(1, 1'b1, BASE + 20'd8, 16'h0000, 2'b00, -1, 16'h0);

    repeat (300) begin
      g = int'($urandom_range(0, NI - 1));
      a = BASE - 20'd4 + 20'(2 * $urandom_range(0, 11));
      if ($urandom_range(0, 7) == 0) a[0] = 1'b1;
      ab = -1;
      if (WS_TAB[g] > 0 && $urandom_range(0, 7) == 0) ab = int'($urandom_range(0, WS_TAB[g] - 1));
      xfer(g, 1'($urandom), a, 16'($urandom), 2'($urandom), ab, 16'($urandom));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
    end

    // reset in the middle of a write abandons it
    psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = BASE + 20'd2; pwdata = 16'hDEAD; pstrb = 2'b11;
    @(posedge clk); #1;
    penable = 1'b1;
    reset = 1'b1;
    for (int i = 0; i < NI; i++) mdl[i] = '0;
    @(posedge clk); #1;
    reset = 1'b0; psel = '0; penable = 1'b0;
    repeat (6) begin
      @(negedge clk); chk("rst_mid_rdy", 128'(pready[2]), 128'(0));
    end
    chk("rst_mid_reg", 128'(regs[2][31:16]), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
